// File: rtl/test_reg_axil_slave.sv
// AXI4-Lite register endpoint: two RW operands, their sum, and a write-commit counter.
// Write and read channels run as independent FSMs; every output comes straight from a flop.
//
// Write FSM  state     | meaning
//            W_IDLE    | ready for AW and W
//            W_HAVE_AW | address held, waiting for data
//            W_HAVE_W  | data held, waiting for address
//            W_RESP    | commit done, bvalid until bready
// Read FSM   R_IDLE    | arready high, waiting for AR
//            R_DATA    | rvalid high until rready
module test_reg_axil_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t             wr_state_q, wr_state_d;
    rd_state_t             rd_state_q, rd_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [IW-1:0]         awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
    logic [DATA_WIDTH-1:0] reg2_q, reg2_d;
    logic [DATA_WIDTH-1:0] reg4_q, reg4_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit, cm_okay;
    logic [IW-1:0]         cm_addr;
    logic [DATA_WIDTH-1:0] cm_data;
    logic [SW-1:0]         cm_strb;
    logic [DATA_WIDTH-1:0] reg3;
    logic [IW-1:0]         ar_idx;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    assign aw_hs  = s_axil_awvalid && awready_q;
    assign w_hs   = s_axil_wvalid && wready_q;
    assign ar_hs  = s_axil_arvalid && arready_q;
    assign reg3   = reg1_q + reg2_q;
    assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:2];

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        cm_addr    = awaddr_q;
        cm_data    = wdata_q;
        cm_strb    = wstrb_q;
        cm_okay    = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit  = 1'b1;
                    cm_addr = s_axil_awaddr[ADDR_WIDTH-1:2];
                    cm_data = s_axil_wdata;
                    cm_strb = s_axil_wstrb;
                end else if (aw_hs) begin
                    awaddr_d   = s_axil_awaddr[ADDR_WIDTH-1:2];
                    wr_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d    = s_axil_wdata;
                    wstrb_d    = s_axil_wstrb;
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit  = 1'b1;
                    cm_data = s_axil_wdata;
                    cm_strb = s_axil_wstrb;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit  = 1'b1;
                    cm_addr = s_axil_awaddr[ADDR_WIDTH-1:2];
                end
            end
            W_RESP: begin
                if (s_axil_bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        cm_okay = (cm_addr == IW'(0)) || (cm_addr == IW'(1));
        if (commit) begin
            wr_state_d = W_RESP;
            bresp_d    = cm_okay ? RESP_OKAY : RESP_SLVERR;
        end
        awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_W);
        wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_HAVE_AW);
        bvalid_d  = (wr_state_d == W_RESP);
    end

    always_comb begin
        reg1_d = reg1_q;
        reg2_d = reg2_q;
        reg4_d = reg4_q;
        if (commit && cm_okay) begin
            reg4_d = reg4_q + DATA_WIDTH'(1);
            for (int i = 0; i < SW; i++) begin
                if (cm_strb[i]) begin
                    if (cm_addr == IW'(0)) reg1_d[8*i +: 8] = cm_data[8*i +: 8];
                    else                   reg2_d[8*i +: 8] = cm_data[8*i +: 8];
                end
            end
        end
    end

    // Read data is sampled from the pre-update registers, so a same-edge commit is not visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    rresp_d    = RESP_OKAY;
                    case (ar_idx)
                        IW'(0):  rdata_d = reg1_q;
                        IW'(1):  rdata_d = reg2_q;
                        IW'(2):  rdata_d = reg3;
                        IW'(3):  rdata_d = reg4_q;
                        default: begin
                            rdata_d = '0;
                            rresp_d = RESP_SLVERR;
                        end
                    endcase
                end
            end
            R_DATA: begin
                if (s_axil_rready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            reg1_q     <= '0;
            reg2_q     <= '0;
            reg4_q     <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
            reg4_q     <= reg4_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

endmodule

// File: doc/test_reg_axil_slave.md
Name: test_reg_axil_slave

Overview:
- AXI4-Lite slave register block in the user logic; it is the register endpoint driven by the shell's AXI-Lite master (axi_l_wr / axi_l_rd tasks in simulation).
- Holds two RW operands, a read-only sum and a read-only write-commit counter.
- Lets host software check the control path end-to-end: write A and B, read back A+B.

Parameters:
ADDR_WIDTH, 16, AXI-Lite address width; decode uses addr[ADDR_WIDTH-1:2], addr[1:0] ignored
DATA_WIDTH, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous, active-low reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready

Behaviour:
- Register map:
  - 0x0 REG1: RW
  - 0x4 REG2: RW
  - 0x8 REG3: RO, REG1+REG2 modulo 2^32, combinational from the stored registers
  - 0xC REG4: RO, count of OKAY write commits, wraps 0xFFFFFFFF->0
  - Every address >= 0x10 is unmapped.
- Reset (rst_n low, asynchronous): REG1=REG2=REG4=0; all ready and valid outputs 0; bresp=rresp=0; rdata=0. From the first clock after rst_n deasserts: awready=wready=arready=1.
- Write channel:
  - AW and W are captured independently. awready drops after the AW handshake; wready drops after the W handshake. Each stays low until the B handshake.
  - Commit happens on the edge where the second of AW/W is captured; if both are captured on the same edge, commit happens on that edge.
  - At commit: byte lanes with wstrb=1 update REG1/REG2. bvalid=1 is asserted from the next cycle. REG4 increments on OKAY commits only.
  - Writes to 0x8, 0xC or unmapped addresses change no register and return bresp=SLVERR (2'b10). Otherwise bresp=OKAY (2'b00).
  - bvalid and bresp hold until bready; after the handshake, awready=wready=1 on the next cycle.
  - wstrb=0 to REG1/REG2 gives OKAY, leaves data unchanged, and still increments REG4.
- Read channel:
  - arready=1 when idle. On the AR handshake, rdata/rresp are registered, rvalid=1 from the next cycle, and arready=0.
  - Unmapped addresses return rdata=0, rresp=SLVERR.
  - rdata/rresp/rvalid hold stable until rready; arready returns to 1 on the cycle after the R handshake.
  - Read latency: 1 cycle from AR handshake to rvalid.
- Read and write are independent FSMs.
  - Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP.
  - Read FSM states: IDLE, DATA.
- Simultaneous write commit and AR handshake on the same edge: the read returns pre-write values for all registers, including REG3 and REG4.
- No combinational path from any input to any output.
- Reset mid-transaction: everything returns to reset state immediately; pending B/R responses are dropped.

Test Plan:
- Write REG1=0x12345678 and REG2=0x11111111 (wstrb 0xF), then read 0x8 -> rdata 0x23456789, rresp OKAY; then read 0xC -> 0x00000002.
- Write REG1=0xFFFFFFFF and REG2=0x00000002, then read 0x8 -> 0x00000001 (wrap). Write 0x8 -> bresp SLVERR; REG3 and REG4 are unchanged.
- With REG1=0x00000000, write 0xAABBCCDD to 0x0 with wstrb=0b0101 -> REG1 reads 0x00BB00DD.
- Present W three cycles before AW, with bready held low for 5 cycles -> a single commit; bvalid is held for 6 cycles; awready and wready stay 0 until the B handshake.
- Read 0x40 -> rdata 0, rresp SLVERR. Hold rready low for 4 cycles -> rvalid and rdata stay stable for the whole stall; arready is 0 throughout.
- Issue a write REG1=5 that commits on the same edge as the AR handshake for a read of 0x0 (old value 3) -> the read returns 3 and a subsequent read returns 5. Then pulse rst_n low while bvalid=1 -> all registers read 0 afterwards and bvalid=0.
